// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: stalls a CPU data port while it runs one access over a valid/ready request, pulse-response bus.
// Ports: clk, rst (sync, active-low); CPU side cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_stall;
//   bus side mem_req_valid/mem_we/mem_addr/mem_wdata with mem_req_ready, response mem_resp_valid/mem_rdata.
// Option: define CPU_MEM_BRIDGE_LASTREAD_EN to add a one-entry last-read buffer that answers repeat reads without stalling.
module cpu_mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] rdata_q;
  logic hit;
`ifdef CPU_MEM_BRIDGE_LASTREAD_EN
  logic        buf_v;
  logic [29:0] buf_a;
  logic [31:0] buf_d;
  assign hit = state == IDLE && cpu_req && cpu_we == 4'b0 && buf_v && buf_a == cpu_addr[31:2];
  always_ff @(posedge clk)
    if (!rst) begin
      buf_v <= 1'b0;
      buf_a <= '0;
      buf_d <= '0;
    end else if (state == WAIT && mem_resp_valid && mem_we == 4'b0) begin
      buf_v <= 1'b1;
      buf_a <= mem_addr[31:2];
      buf_d <= mem_rdata;
    end else if (state == IDLE && cpu_req && cpu_we != 4'b0 && buf_a == cpu_addr[31:2])
      buf_v <= 1'b0;
  // buf_d always mirrors rdata_q's last read, but it is muxed in only on a hit
  assign cpu_rdata = hit ? buf_d : rdata_q;
`else
  assign hit = 1'b0;
  assign cpu_rdata = rdata_q;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_req && !hit) begin
        mem_addr  <= cpu_addr & 32'hFFFF_FFFC;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end
      if (state == WAIT && mem_resp_valid && mem_we == 4'b0) rdata_q <= mem_rdata;
    end
  // responses are only looked at in WAIT, so one arriving with acceptance is dropped
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cpu_req && !hit ? REQ : IDLE;
      REQ:     state_nx = mem_req_ready ? WAIT : REQ;
      WAIT:    state_nx = mem_resp_valid ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  assign mem_req_valid = state == REQ;
  assign cpu_stall = cpu_req && state != DONE && !hit;
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: scoreboard bench for cpu_mem_bridge with a bus responder and a word-array reference model.
module tb_cpu_mem_bridge;
  logic clk = 0, rst = 0, cpu_req = 0;
  logic [3:0] cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [31:0] cpu_rdata;
  logic cpu_stall, mem_req_valid;
  logic mem_req_ready = 0;
  logic [3:0] mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_resp_valid = 0;
  logic [31:0] mem_rdata = 0;
  always #5 clk = ~clk;
  cpu_mem_bridge dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );
  typedef struct packed {logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;} bus_t;
  int checks = 0, errors = 0;
  bus_t bus_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] bus_mem [256];
  logic m_bv = 0;
  logic [29:0] m_ba = 0;
  logic [31:0] last_rd = 0;
  int rdy_delay = 0, resp_delay = 0, inject = 0, resp_cnt = 0;
  logic pend = 0, in_req = 0;
  int rcnt = 0, wcnt = 0;
  logic [31:0] rd_hold = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] bmask(input logic [3:0] we);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{we[b]}};
    return m;
  endfunction
  initial begin
    bus_t e;
    int w;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      mem_req_ready = 0;
      if (pend) begin
        if (rcnt == 0) begin
          mem_resp_valid = 1;
          mem_rdata = rd_hold;
          pend = 0;
          resp_cnt++;
        end else rcnt--;
      end else if (inject == 2 || (inject == 1 && $urandom_range(0, 2) == 0)) begin
        mem_resp_valid = 1;
        mem_rdata = $urandom;
      end
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          wcnt = rdy_delay;
        end
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_req actual=%h required=none", mem_addr);
        end else begin
          e = bus_q[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {28'b0, mem_we}, {28'b0, e.we});
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        if (wcnt == 0) begin
          mem_req_ready = 1;
          in_req = 0;
          if (bus_q.size() > 0) void'(bus_q.pop_front());
          w = int'(mem_addr[9:2]);
          if (mem_we == 4'b0) rd_hold = bus_mem[w];
          else bus_mem[w] = (bus_mem[w] & ~bmask(mem_we)) | (mem_wdata & bmask(mem_we));
          pend = 1;
          rcnt = resp_delay;
        end else wcnt--;
      end
    end
  end
  always @(negedge clk)
    if (rst && cpu_req && !cpu_stall) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=none", cpu_rdata);
      end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd, output int stalls);
    bus_t e;
    int w, start;
    bit hit;
    w = int'(addr[9:2]);
    hit = 0;
`ifdef CPU_MEM_BRIDGE_LASTREAD_EN
    hit = we == 4'b0 && m_bv && m_ba == addr[31:2];
`endif
    if (!hit) begin
      e.addr = addr & 32'hFFFF_FFFC;
      e.we = we;
      e.wdata = wd;
      bus_q.push_back(e);
    end
    if (we == 4'b0) begin
      last_rd = ref_mem[w];
      m_bv = 1;
      m_ba = addr[31:2];
    end else begin
      ref_mem[w] = (ref_mem[w] & ~bmask(we)) | (wd & bmask(we));
      if (m_ba == addr[31:2]) m_bv = 0;
    end
    cpu_q.push_back(last_rd);
    start = resp_cnt;
    cpu_req = 1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 100) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout actual=%0d required=<=100", stalls);
        break;
      end
    end
    chk("resp_before_done", (resp_cnt > start) ? 1 : 0, hit ? 0 : 1);
    @(posedge clk);
    #1;
    cpu_req = 0;
    cpu_we = 0;
  endtask
  initial begin
    int st;
    logic [3:0] we;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = i * 32'h0101_0101 ^ 32'h3C96_0000;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[8'h41] = 32'hDEAD_BEEF;
    bus_mem[8'h41] = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hA5A5_A5A5;
    bus_mem[8'h10] = 32'hA5A5_A5A5;
    rst = 0;
    cpu_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 0);
    chk("rst_mem_we", {28'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_stall", {31'b0, cpu_stall}, 1);
    @(posedge clk);
    #1;
    cpu_req = 0;
    rst = 1;
    access(4'b0, 32'h0000_0104, 32'h1111_2222, st);
    chk("lat_read", st, 3);
    rdy_delay = 4;
    access(4'b0011, 32'h0000_0206, 32'h1234_5678, st);
    chk("lat_store", st, 7);
    rdy_delay = 0;
    inject = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_spurious_rdata", cpu_rdata, last_rd);
    @(posedge clk);
    #1;
    access(4'b0, 32'h0000_0104, 32'h0, st);
    chk("lat_spurious", st, 3);
    rdy_delay = 2;
    access(4'b0, 32'h0000_0208, 32'h0, st);
    chk("lat_spurious_rdy2", st, 5);
    inject = 0;
    rdy_delay = 0;
    resp_delay = 6;
    begin
      bus_t e;
      e.addr = 32'h0000_0080;
      e.we = 4'b0;
      e.wdata = 32'h0;
      bus_q.push_back(e);
    end
    cpu_req = 1;
    cpu_we = 0;
    cpu_addr = 32'h0000_0080;
    cpu_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wait_req_valid", {31'b0, mem_req_valid}, 0);
    chk("wait_stall", {31'b0, cpu_stall}, 1);
    rst = 0;
    @(negedge clk);
    chk("abort_req_valid", {31'b0, mem_req_valid}, 0);
    chk("abort_cpu_rdata", cpu_rdata, 0);
    chk("abort_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    cpu_req = 0;
    @(posedge clk);
    #1;
    rst = 1;
    last_rd = 0;
    m_bv = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("late_resp_rdata", cpu_rdata, 0);
    chk("late_resp_req_valid", {31'b0, mem_req_valid}, 0);
    @(posedge clk);
    #1;
    resp_delay = 0;
    access(4'b0, 32'h0000_0040, 32'h0, st);
    chk("buf_first_read", st, 3);
    access(4'b0, 32'h0000_0040, 32'h0, st);
`ifdef CPU_MEM_BRIDGE_LASTREAD_EN
    chk("buf_hit_read", st, 0);
`else
    chk("buf_hit_read", st, 3);
`endif
    access(4'b1111, 32'h0000_0040, 32'h0BAD_F00D, st);
    access(4'b0, 32'h0000_0040, 32'h0, st);
    chk("buf_after_write", st, 3);
    inject = 1;
    for (int i = 0; i < 80; i++) begin
      rdy_delay = $urandom_range(0, 3);
      resp_delay = $urandom_range(0, 3);
      we = $urandom_range(0, 1) ? 4'b0 : 4'($urandom_range(1, 15));
      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      access(we, a, $urandom, st);
    end
    inject = 0;
    repeat (4) @(posedge clk);
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- cpu_req  in  1  CPU data-port access request (chip select).
- cpu_we  in  4  byte write enables, active-high; 4'b0000 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  holds the CPU pipeline while high.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus request accepted.
- mem_we  out  4  registered byte enables.
- mem_addr  out  32  registered word address.
- mem_wdata  out  32  registered store data.
- mem_resp_valid  in  1  bus response, one-cycle pulse; sent for reads and writes.
- mem_rdata  in  32  response data, valid with mem_resp_valid.

Function
REQ-002 The block SHALL implement the FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
REQ-003 In IDLE, when cpu_req=1, the block SHALL register {cpu_addr[31:2],2'b00}, cpu_we and cpu_wdata, and SHALL go to REQ.
REQ-004 cpu_stall SHALL equal cpu_req AND (state != DONE), except for a buffer hit (REQ-011).
REQ-005 In REQ, mem_req_valid SHALL be 1, and the registered addr, we and wdata SHALL stay stable until mem_req_ready=1; the block SHALL then go to WAIT.
REQ-006 mem_resp_valid SHALL be ignored in any state other than WAIT. A response in the same cycle as acceptance SHALL NOT be recognised.
REQ-007 In WAIT, on mem_resp_valid=1, the block SHALL latch mem_rdata into cpu_rdata (reads only) and go to DONE.
REQ-008 In DONE, cpu_stall SHALL be 0 for exactly one cycle, and the block SHALL return to IDLE. A new cpu_req is accepted in IDLE on the next cycle.
REQ-009 Minimum latency SHALL be 3 stall cycles (REQ, WAIT, DONE entry) when ready and resp are immediate. There SHALL be no upper bound and no timeout.
REQ-010 cpu_rdata SHALL hold its last value outside DONE. Writes SHALL NOT change cpu_rdata.

Reset
REQ-012 While rst=0 the block SHALL force state=IDLE, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 and buffer valid=0. cpu_stall SHALL follow REQ-004 with state IDLE.
REQ-013 A reset asserted mid-transaction SHALL abort it. mem_req_valid SHALL drop in the cycle after the sampling edge, and any later mem_resp_valid SHALL be ignored.

Configuration
REQ-011 With macro CPU_MEM_BRIDGE_LASTREAD_EN defined, the block SHALL add a one-entry buffer holding {valid, word addr, data}, loaded on every completed read.
- In IDLE, a read whose word address equals the buffer address while valid=1 SHALL return the buffered data combinationally on cpu_rdata, with cpu_stall=0 and no bus request.
- Any write whose word address matches SHALL clear valid when it is accepted in IDLE.
- With the macro undefined, no buffer SHALL exist, and every access SHALL use the FSM path.

Verification
REQ-014 Read addr 0x0000_0104, bus ready and resp immediate, mem_rdata=0xDEADBEEF -> mem_addr=0x104, stall high for 3 cycles, cpu_rdata=0xDEADBEEF in DONE.
REQ-015 Store cpu_we=4'b0011, addr 0x0000_0206, wdata 0x1234_5678, ready held low for 4 cycles -> mem_addr=0x204, we and wdata stable throughout REQ, stall released only after resp.
REQ-016 mem_resp_valid pulsed in IDLE and in REQ -> no state change, cpu_rdata unchanged.
REQ-017 rst=0 asserted during WAIT, then resp arrives -> state IDLE, mem_req_valid=0, cpu_rdata=0, response ignored.
REQ-018 Macro defined: read 0x40 (0xA5A5A5A5), read 0x40 again -> second read has stall=0 and no mem_req_valid. Then write 0x40 and read 0x40 -> bus read issued.
